// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the parametrised APB master bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DECERR
    } state_e;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational slave-index decode: one-hot select plus out-of-range flag.
module apb_slave_decode
    import apb_bridge_pkg::*;
#(
    parameter int unsigned NSLV = 2,
    parameter int unsigned SW   = clog2_min1(NSLV)
) (
    input  logic [SW-1:0]   idx,
    output logic [NSLV-1:0] sel,
    output logic            dec_err
);

    // An index past the last slave leaves sel empty, which is the decode error.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            sel[i] = (32'(idx) == i);
        end
        dec_err = ~|sel;
    end

endmodule

// File: rtl/apb_master_bridge_n.sv
// APB master bridge: valid/ready single requests to one of NSLV APB slaves.
// Define APB_BRIDGE_PSTRB_EN to add req_strb/PSTRB (APB4 write strobes).
module apb_master_bridge_n
    import apb_bridge_pkg::*;
#(
    parameter int unsigned AW      = 9,
    parameter int unsigned DW      = 8,
    parameter int unsigned NSLV    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AW-1:0]      req_addr,
    input  logic [DW-1:0]      req_wdata,
`ifdef APB_BRIDGE_PSTRB_EN
    input  logic [DW/8-1:0]    req_strb,
    output logic [DW/8-1:0]    PSTRB,
`endif
    output logic               rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [NSLV-1:0]    PSEL,
    output logic               PENABLE,
    output logic [AW-1:0]      PADDR,
    output logic               PWRITE,
    output logic [DW-1:0]      PWDATA,
    input  logic [NSLV*DW-1:0] PRDATA,
    input  logic [NSLV-1:0]    PREADY,
    input  logic [NSLV-1:0]    PSLVERR
);

    localparam int unsigned SW    = clog2_min1(NSLV);
    localparam int unsigned CW    = clog2_min1(TIMEOUT + 1);
    localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_e          state_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [NSLV-1:0] dec_sel;
    logic            dec_err;
    logic            acc_ready;
    logic            acc_err;
    logic [DW-1:0]   acc_rdata;
    logic            timeout_hit;

    apb_slave_decode #(
        .NSLV (NSLV),
        .SW   (SW)
    ) u_decode (
        .idx     (req_addr[AW-1 -: SW]),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    // Gating with PRESETn keeps req_ready low while reset is held.
    assign req_ready = PRESETn && (state_q == IDLE);

    // PSEL is held through ACCESS, so it selects the live slave's return lines.
    always_comb begin
        acc_ready = 1'b0;
        acc_err   = 1'b0;
        acc_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (PSEL[i]) begin
                acc_ready = PREADY[i];
                acc_err   = PSLVERR[i];
                acc_rdata = PRDATA[i*DW +: DW];
            end
        end
        timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CW'(TLAST));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            PSEL       <= '0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef APB_BRIDGE_PSTRB_EN
            PSTRB      <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        PADDR      <= req_addr;
                        PWRITE     <= req_write;
                        PWDATA     <= req_wdata;
                        wait_cnt_q <= '0;
                        if (dec_err) begin
                            state_q <= DECERR;
                        end else begin
                            state_q <= SETUP;
                            PSEL    <= dec_sel;
`ifdef APB_BRIDGE_PSTRB_EN
                            PSTRB   <= req_write ? req_strb : '0;
`endif
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (acc_ready || timeout_hit) begin
                        state_q   <= IDLE;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
`ifdef APB_BRIDGE_PSTRB_EN
                        PSTRB     <= '0;
`endif
                        // A ready slave wins over a timeout landing on the same cycle.
                        if (acc_ready) begin
                            rsp_err   <= acc_err ? RSP_ERR : RSP_OK;
                            rsp_rdata <= (acc_err || PWRITE) ? '0 : acc_rdata;
                        end else begin
                            rsp_err   <= RSP_ERR;
                            rsp_rdata <= '0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                DECERR: begin
                    state_q   <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= RSP_ERR;
                    rsp_rdata <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
